lsab_sched: RTL
===============

# lsab_sched

Request scheduler for the four-lane LSAB FIFO block: it shares the block's single write port and single read port among four producer lanes and four consumer lanes. It drives `WRITE`/`WRITE_FIFO` and `READ`/`READ_FIFO`, and grants access round-robin with a bounded burst length. It honours the per-lane `STOP` flags and holds a lane's reads after that lane raises an interrupt. It also tags returning read data with its lane, so consumers can demultiplex `OUT`.

## Interface
- `BURST`, default 4: maximum consecutive grants to one lane while other lanes are eligible; legal range 1..15.
- `CLK`  in  1  system clock.
- `RST`  in  1  synchronous reset, active-high.
- `WREQ`  in  4  lane n producer holds a word for FIFO n.
- `WFULL`  in  4  lane n FIFO full.
- `WGNT`  out  4  one-hot; the lane n word is written this cycle (combinational).
- `WRITE`  out  1  to FIFO block; equals `|WGNT`.
- `WRITE_FIFO`  out  2  lane index of the write.
- `RREQ`  in  4  lane n consumer wants a word.
- `STOP`  in  4  lane n `STOP_x` from the FIFO block.
- `INT`  in  4  lane n `INT_OUT_x` pulse from the FIFO block.
- `INT_ACK`  in  4  lane n consumer has serviced its interrupt.
- `RGNT`  out  4  one-hot read grant (combinational).
- `READ`  out  1  to FIFO block; equals `|RGNT`.
- `READ_FIFO`  out  2  lane index of the read.
- `INT_PEND`  out  4  sticky per-lane interrupt pending.
- `RVALID`  out  1  FIFO `OUT` holds a word read under this scheduler.
- `RLANE`  out  2  lane of that word.

## Operation
Write eligibility and read eligibility are defined per lane:
- Write-eligible lanes: `WREQ & ~WFULL`.
- Read-eligible lanes: `RREQ & ~STOP & ~INT_PEND`.

Each side has an independent arbiter built from identical logic. Its state is a 2-bit last-granted lane `cur` and a 4-bit burst counter `cnt`. The selection rule each cycle is:
- If `cur` is eligible and (`cnt < BURST` or no other lane is eligible): grant `cur`.
- Otherwise: grant the first eligible lane scanning `cur+1`, `cur+2`, `cur+3`, `cur` (mod 4).
- If no lane is eligible: no grant; `cur` and `cnt` hold.

State update on the clock edge:
- Grant to `cur`: `cnt <= (cnt == BURST) ? 1 : cnt + 1`.
- Grant to another lane: `cur` <= that lane, `cnt <= 1`.

Port driving:
- `WRITE_FIFO`/`READ_FIFO` show the granted lane when granting; otherwise they show `cur`, held stable.
- The write grant and the read grant are independent. Both may fire in the same cycle, on the same lane or on different lanes.

Interrupt handling:
- `INT[n]` sets `INT_PEND[n]`; `INT_ACK[n]` clears it.
- If set and ack occur in the same cycle, set wins and the bit stays 1.
- `INT_PEND[n]` masks reads on lane n from the cycle after it is set.

Read-return tagging:
- A 2-stage pipeline carries `READ` and `READ_FIFO`, matching the FIFO read latency (SRAM registered read, then the `OUT` register).
- `RVALID`/`RLANE` are the stage-2 outputs.

## Timing
Reset (synchronous, while `RST` is high):
- `WGNT`, `RGNT`, `WRITE`, `READ` forced to 0 regardless of requests.
- `WRITE_FIFO`, `READ_FIFO`, `INT_PEND`, `RVALID`, `RLANE` are 0.
- `cur` = 3, so lane 0 wins first after reset; `cnt` = 0.
- Reset asserted mid-burst or with reads in flight discards all state; in-flight `RVALID` is never emitted.

Latencies and handshakes:
- Grants are combinational from requests in the same cycle. The producer's word is consumed at the edge ending a cycle with its `WGNT` bit high.
- Requests must hold until granted.
- `RVALID` is high exactly 2 cycles after the cycle with `READ` high. `OUT` is valid in that same cycle, and `RLANE` equals that cycle's earlier `READ_FIFO`.
- Back-to-back reads yield back-to-back `RVALID`.

`STOP` and `INT` are registered FIFO outputs:
- A read granted in cycle t may raise `STOP[n]` in t+1. No read is granted on lane n in t+1.
- An `INT[n]` seen in cycle t masks lane n from t+1.

Widths and wrap:
- The lane scan wraps mod 4.
- `cnt` never exceeds `BURST`.
- With `BURST`=1, an eligible competing lane always rotates the grant.

## Test plan
- Reset then all four `WREQ` high, `WFULL`=0, `BURST`=4 → `WRITE_FIFO` sequence 0,0,0,0,1,1,1,1,2,…; `WGNT` one-hot every cycle.
- Only lane 2 requests reads for 10 cycles, `STOP`=0 → `RGNT`=4'b0100 all 10 cycles. `RVALID`/`RLANE`=2 appear 2 cycles after each read, for 10 consecutive cycles.
- Lanes 1 and 3 request reads; `STOP[1]` rises after 2 lane-1 reads → grants move to lane 3 next cycle, and lane 1 is never granted while `STOP[1]`=1.
- `INT[0]` pulse while lane 0 is reading → `INT_PEND`=4'b0001 next cycle and lane 0 reads stop. `INT_ACK[0]` and `INT[0]` in the same cycle → pending stays 1. A lone `INT_ACK[0]` then clears it and lane 0 reads resume.
- Simultaneous write to lane 1 and read from lane 1 → `WRITE`=`READ`=1, both FIFO indices 1, in the same cycle.
- Assert `RST` one cycle after a read grant → `RVALID` stays 0 and all outputs return to reset values. After release, the first grant goes to the lowest-index requester.

Source files
------------

// File: rtl/lsab_sched_if.sv
// Request/grant and read-return bundle between the LSAB FIFO lanes and lsab_sched.
// The master side drives requests and FIFO status. The slave side is the scheduler.
interface lsab_sched_if;
  logic [3:0] WREQ;
  logic [3:0] WFULL;
  logic [3:0] WGNT;
  logic       WRITE;
  logic [1:0] WRITE_FIFO;
  logic [3:0] RREQ;
  logic [3:0] STOP;
  logic [3:0] INT;
  logic [3:0] INT_ACK;
  logic [3:0] RGNT;
  logic       READ;
  logic [1:0] READ_FIFO;
  logic [3:0] INT_PEND;
  logic       RVALID;
  logic [1:0] RLANE;

  modport master (
    output WREQ, WFULL, RREQ, STOP, INT, INT_ACK,
    input  WGNT, WRITE, WRITE_FIFO, RGNT, READ, READ_FIFO, INT_PEND, RVALID, RLANE
  );

  modport slave (
    input  WREQ, WFULL, RREQ, STOP, INT, INT_ACK,
    output WGNT, WRITE, WRITE_FIFO, RGNT, READ, READ_FIFO, INT_PEND, RVALID, RLANE
  );
endinterface

// File: rtl/lsab_sched.sv
// Shares the LSAB FIFO write and read ports among four lanes, using round-robin with a bounded burst.
// It also tags returning read data with the lane it was read for.
module lsab_sched #(
  parameter int BURST = 4
) (
  input logic         CLK,
  input logic         RST,
  lsab_sched_if.slave bus
);

  localparam logic [3:0] BURST_L = 4'(BURST);

  logic [1:0] w_cur, r_cur;
  logic [3:0] w_cnt, r_cnt;
  logic [3:0] pend;
  logic       rv1, rv2;
  logic [1:0] rl1, rl2;
  logic [3:0] w_elig, r_elig;
  logic [2:0] w_pick, r_pick;
  logic [3:0] wgnt, rgnt;

  // Returns {grant_valid, lane}. The lane field is cur when there is no grant.
  // cnt == 0 means that no burst has started yet. In that case cur gets no
  // preference, so after reset the scan starts at cur+1 (lane 0).
  function automatic logic [2:0] arb_pick(input logic [3:0] elig,
                                          input logic [1:0] cur,
                                          input logic [3:0] cnt);
    logic [3:0] others;
    logic [1:0] idx;
    logic [2:0] res;
    res    = {1'b0, cur};
    others = elig & ~(4'b0001 << cur);
    if (elig[cur] && (cnt != 4'd0) && ((cnt < BURST_L) || (others == 4'b0000))) begin
      res = {1'b1, cur};
    end else begin
      for (int k = 1; k <= 4; k++) begin
        idx = cur + 2'(k);
        if (!res[2] && elig[idx]) res = {1'b1, idx};
      end
    end
    return res;
  endfunction

  always_comb begin
    w_elig = bus.WREQ & ~bus.WFULL;
    r_elig = bus.RREQ & ~bus.STOP & ~pend;
    w_pick = arb_pick(w_elig, w_cur, w_cnt);
    r_pick = arb_pick(r_elig, r_cur, r_cnt);
    wgnt   = (!RST && w_pick[2]) ? (4'b0001 << w_pick[1:0]) : 4'b0000;
    rgnt   = (!RST && r_pick[2]) ? (4'b0001 << r_pick[1:0]) : 4'b0000;
  end

  assign bus.WGNT       = wgnt;
  assign bus.WRITE      = |wgnt;
  assign bus.WRITE_FIFO = RST ? 2'd0 : w_pick[1:0];
  assign bus.RGNT       = rgnt;
  assign bus.READ       = |rgnt;
  assign bus.READ_FIFO  = RST ? 2'd0 : r_pick[1:0];
  assign bus.INT_PEND   = RST ? 4'b0000 : pend;
  assign bus.RVALID     = rv2 && !RST;
  assign bus.RLANE      = RST ? 2'd0 : rl2;

  always_ff @(posedge CLK) begin
    if (RST) begin
      w_cur <= 2'd3;
      w_cnt <= 4'd0;
      r_cur <= 2'd3;
      r_cnt <= 4'd0;
      pend  <= 4'b0000;
      rv1   <= 1'b0;
      rv2   <= 1'b0;
      rl1   <= 2'd0;
      rl2   <= 2'd0;
    end else begin
      if (w_pick[2]) begin
        if (w_pick[1:0] == w_cur) begin
          w_cnt <= (w_cnt == BURST_L) ? 4'd1 : w_cnt + 4'd1;
        end else begin
          w_cur <= w_pick[1:0];
          w_cnt <= 4'd1;
        end
      end
      if (r_pick[2]) begin
        if (r_pick[1:0] == r_cur) begin
          r_cnt <= (r_cnt == BURST_L) ? 4'd1 : r_cnt + 4'd1;
        end else begin
          r_cur <= r_pick[1:0];
          r_cnt <= 4'd1;
        end
      end
      // When set and ack arrive together, set wins.
      pend <= (pend & ~bus.INT_ACK) | bus.INT;
      // These two stages match the SRAM read register plus the OUT register.
      rv1  <= r_pick[2];
      rl1  <= r_pick[1:0];
      rv2  <= rv1;
      rl2  <= rl1;
    end
  end

endmodule
